// File: rtl/oled_line_sched.sv
// Round-robin arbiter sharing one OLED character-write port among four line requesters.
// Optional build macro OLED_BLANK_PAD_EN: a fetched NUL blanks the rest of the line with spaces.
module oled_line_sched #(
  parameter int LINE_LEN = 16,
  parameter int COL_W    = 4,
  parameter int CHAR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  output logic [1:0]        rd_sel,
  output logic [COL_W-1:0]  rd_idx,
  input  logic [CHAR_W-1:0] rd_char,
  output logic              oled_wr_en,
  input  logic              oled_ready,
  output logic [1:0]        oled_row,
  output logic [COL_W-1:0]  oled_col,
  output logic [CHAR_W-1:0] oled_char,
  output logic [3:0]        done,
  output logic              busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_LEN - 1);
`ifdef OLED_BLANK_PAD_EN
  localparam logic [CHAR_W-1:0] SPACE = CHAR_W'(32'h20);
`endif

  logic [1:0]        state_q, state_d;
  logic [3:0]        pend_q, pend_d;
  logic [3:0]        pend_clr;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        grant_q, grant_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [1:0]        rd_sel_q, rd_sel_d;
  logic [COL_W-1:0]  rd_idx_q, rd_idx_d;
  logic [CHAR_W-1:0] char_q, char_d;
  logic              first_q, first_d;
  logic [1:0]        arb_gnt;
  logic [CHAR_W-1:0] wr_char;
`ifdef OLED_BLANK_PAD_EN
  logic              pad_q, pad_d;
`endif

  // Scan from ptr+4 down to ptr+1 so the nearest pending requester after ptr wins.
  always_comb begin
    logic [1:0] cand;
    cand    = '0;
    arb_gnt = '0;
    for (int k = 4; k >= 1; k--) begin
      cand = ptr_q + 2'(k);
      if (pend_q[cand]) begin
        arb_gnt = cand;
      end
    end
  end

  // The source answers one cycle after the address, so the character first
  // appears in the opening WRITE cycle and is held in char_q from then on.
  always_comb begin
`ifdef OLED_BLANK_PAD_EN
    wr_char = (pad_q || (rd_char == '0)) ? SPACE : rd_char;
`else
    wr_char = rd_char;
`endif
  end

  always_comb begin
    state_d  = state_q;
    pend_clr = '0;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    col_d    = col_q;
    rd_sel_d = rd_sel_q;
    rd_idx_d = rd_idx_q;
    char_d   = char_q;
    first_d  = first_q;
`ifdef OLED_BLANK_PAD_EN
    pad_d    = pad_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (pend_q != 4'b0000) begin
          grant_d            = arb_gnt;
          ptr_d              = arb_gnt;
          pend_clr[arb_gnt]  = 1'b1;
          col_d              = '0;
          rd_sel_d           = arb_gnt;
          rd_idx_d           = '0;
`ifdef OLED_BLANK_PAD_EN
          pad_d              = 1'b0;
`endif
          state_d            = S_FETCH;
        end
      end

      S_FETCH: begin
        first_d = 1'b1;
        state_d = S_WRITE;
      end

      S_WRITE: begin
        if (first_q) begin
          char_d  = wr_char;
          first_d = 1'b0;
`ifdef OLED_BLANK_PAD_EN
          pad_d   = pad_q | (rd_char == '0);
`endif
        end
        if (oled_ready) begin
          if (col_q == LAST_COL) begin
            state_d = S_DONE;
          end else begin
            col_d   = col_q + 1'b1;
            state_d = S_FETCH;
`ifdef OLED_BLANK_PAD_EN
            // Once blanking, the source is no longer read and rd_idx parks.
            if (!pad_d) begin
              rd_idx_d = col_q + 1'b1;
            end
`else
            rd_idx_d = col_q + 1'b1;
`endif
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A request landing on the grant cycle survives, forcing one more rewrite.
    pend_d = (pend_q & ~pend_clr) | req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pend_q   <= '0;
      ptr_q    <= 2'd3;
      grant_q  <= '0;
      col_q    <= '0;
      rd_sel_q <= '0;
      rd_idx_q <= '0;
      char_q   <= '0;
      first_q  <= 1'b0;
`ifdef OLED_BLANK_PAD_EN
      pad_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      col_q    <= col_d;
      rd_sel_q <= rd_sel_d;
      rd_idx_q <= rd_idx_d;
      char_q   <= char_d;
      first_q  <= first_d;
`ifdef OLED_BLANK_PAD_EN
      pad_q    <= pad_d;
`endif
    end
  end

  assign rd_sel     = rd_sel_q;
  assign rd_idx     = rd_idx_q;
  assign oled_wr_en = (state_q == S_WRITE);
  assign oled_row   = grant_q;
  assign oled_col   = col_q;
  assign oled_char  = (state_q == S_WRITE && first_q) ? wr_char : char_q;
  assign done       = (state_q == S_DONE) ? (4'b0001 << grant_q) : 4'b0000;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_oled_line_sched.sv
// Bench for oled_line_sched: transaction-level line model plus literal spot checks.
module tb_oled_line_sched;
  localparam int L  = 4;
  localparam int CW = 2;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req;
  logic [1:0]    rd_sel;
  logic [CW-1:0] rd_idx;
  logic [DW-1:0] rd_char;
  logic          oled_wr_en;
  logic          oled_ready;
  logic [1:0]    oled_row;
  logic [CW-1:0] oled_col;
  logic [DW-1:0] oled_char;
  logic [3:0]    done;
  logic          busy;

  always #5 clk = ~clk;

  oled_line_sched #(.LINE_LEN(L), .COL_W(CW), .CHAR_W(DW)) dut (
    .clk(clk), .rst(rst), .req(req),
    .rd_sel(rd_sel), .rd_idx(rd_idx), .rd_char(rd_char),
    .oled_wr_en(oled_wr_en), .oled_ready(oled_ready),
    .oled_row(oled_row), .oled_col(oled_col), .oled_char(oled_char),
    .done(done), .busy(busy)
  );

  // Character source with one cycle of read latency.
  logic [7:0] src [4][4];
  always @(posedge clk) rd_char <= src[rd_sel][rd_idx];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Expected character and read column for line g, column c.
  function automatic logic [7:0] exp_char(int g, int c);
`ifdef OLED_BLANK_PAD_EN
    for (int k = 0; k <= c; k++) if (src[g][k] == 8'h00) return 8'h20;
`endif
    return src[g][c];
  endfunction

  function automatic int exp_ridx(int g, int c);
`ifdef OLED_BLANK_PAD_EN
    for (int k = 0; k < c; k++) if (src[g][k] == 8'h00) return k;
`endif
    return c;
  endfunction

  // Model: pending set, round-robin pointer, and progress through the granted line.
  bit         chk_en = 0;
  bit         m_active = 0, m_gap = 0, m_done_due = 0;
  int         m_g = 0, m_col = 0, m_ptr = 3;
  logic [3:0] m_pend = 4'b0000;
  int         cyc = 0, req0_cyc = 0, done0_cyc = 0, stall_cnt = 0;
  int         done_log[$];
  logic [7:0] acc_char[$];

  always @(negedge clk) begin
    logic       exp_wr;
    logic [3:0] exp_done;
    if (chk_en) begin
      exp_wr   = m_active && !m_gap && !m_done_due;
      exp_done = m_done_due ? (4'b0001 << m_g) : 4'b0000;
      chk("wr_en", oled_wr_en, exp_wr);
      chk("busy", busy, m_active);
      chk("done", done, exp_done);
      if (exp_wr) begin
        chk("row", oled_row, m_g);
        chk("col", oled_col, m_col);
        chk("char", oled_char, exp_char(m_g, m_col));
      end
      if (m_active && m_gap) begin
        chk("rd_sel", rd_sel, m_g);
        chk("rd_idx", rd_idx, exp_ridx(m_g, m_col));
      end
      if (oled_wr_en && !oled_ready) stall_cnt++;
      if (oled_wr_en && oled_ready) acc_char.push_back(oled_char);
      if (req[0]) req0_cyc = cyc;
      if (done[0]) done0_cyc = cyc;
      for (int i = 0; i < 4; i++) if (done[i]) done_log.push_back(i);
`ifdef OLED_BLANK_PAD_EN
      if (rd_sel == 2'd3 && rd_idx == 2'd3) chk("pad_no_read_col3", 1, 0);
`endif
      if (rst) begin
        m_active = 0; m_gap = 0; m_done_due = 0;
        m_ptr = 3; m_pend = 4'b0000; m_col = 0; m_g = 0;
      end else begin
        if (exp_wr) begin
          if (oled_ready) begin
            if (m_col == L - 1) m_done_due = 1;
            else begin
              m_col++;
              m_gap = 1;
            end
          end
        end else if (m_gap) begin
          m_gap = 0;
        end else if (m_done_due) begin
          m_done_due = 0;
          m_active = 0;
        end else if (m_pend != 4'b0000) begin
          for (int k = 1; k <= 4; k++) begin
            if (!m_active && m_pend[(m_ptr + k) % 4]) begin
              m_g = (m_ptr + k) % 4;
              m_active = 1;
            end
          end
          m_pend[m_g] = 1'b0;
          m_ptr = m_g;
          m_col = 0;
          m_gap = 1;
        end
        m_pend = m_pend | req;
      end
      cyc++;
    end
  end

  task automatic pulse(input logic [3:0] v);
    req = v;
    @(posedge clk); #1;
    req = 4'b0000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_quiet(input string nm, input int max);
    bit hit = 0;
    for (int i = 0; i < max && !hit; i++) begin
      @(posedge clk); #1;
      if (!busy && !m_active && m_pend == 4'b0000) hit = 1;
    end
    if (!hit) chk({nm, "_timeout"}, 1, 0);
  endtask

  task automatic wait_wr(input string nm, input int r, input int c, input int max);
    bit hit = 0;
    for (int i = 0; i < max && !hit; i++) begin
      if (oled_wr_en && oled_row == r && oled_col == c) hit = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!hit) chk({nm, "_timeout"}, 1, 0);
  endtask

  task automatic chk_line(input string nm, input logic [31:0] word);
    chk({nm, "_len"}, acc_char.size(), 4);
    if (acc_char.size() == 4) begin
      chk({nm, "_c0"}, acc_char[0], word[31:24]);
      chk({nm, "_c1"}, acc_char[1], word[23:16]);
      chk({nm, "_c2"}, acc_char[2], word[15:8]);
      chk({nm, "_c3"}, acc_char[3], word[7:0]);
    end
  endtask

  task automatic chk_order(input string nm, input int n, input logic [15:0] seq);
    chk({nm, "_cnt"}, done_log.size(), n);
    for (int i = 0; i < n && i < done_log.size(); i++)
      chk({nm, "_idx"}, done_log[i], seq[15 - 4*i -: 4]);
  endtask

  task automatic clear_logs();
    done_log.delete();
    acc_char.delete();
    stall_cnt = 0;
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; oled_ready = 1'b1;
    src[0] = '{8'h50, 8'h52, 8'h43, 8'h45};  // PRCE
    src[1] = '{8'h43, 8'h4F, 8'h49, 8'h4E};  // COIN
    src[2] = '{8'h54, 8'h4F, 8'h54, 8'h4C};  // TOTL
    src[3] = '{8'h44, 8'h49, 8'h00, 8'h58};  // D I NUL X
    @(posedge clk); #1;
    chk_en = 1;
    chk("rst_wr_en", oled_wr_en, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_sel", rd_sel, 0);
    chk("rst_rd_idx", rd_idx, 0);
    chk("rst_row", oled_row, 0);
    chk("rst_col", oled_col, 0);
    chk("rst_char", oled_char, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single line: req cycle, IDLE, 8 fetch/write cycles, DONE = 11 cycles inclusive.
    clear_logs();
    pulse(4'b0001);
    wait_quiet("t1", 60);
    chk_line("t1_line", 32'h50524345);
    chk("t1_latency", done0_cyc - req0_cyc, 10);
    chk_order("t1_order", 1, 16'h0000);
    chk("t1_busy_after", busy, 0);

    // All four at once from a fresh pointer, then 0 and 1 with the pointer at 3.
    do_reset();
    clear_logs();
    pulse(4'b1111);
    wait_quiet("t2a", 200);
    chk_order("t2a_order", 4, 16'h0123);
    clear_logs();
    pulse(4'b0011);
    wait_quiet("t2b", 100);
    chk_order("t2b_order", 2, 16'h0100);

    // Five-cycle back-pressure at column 2.
    clear_logs();
    pulse(4'b0100);
    wait_wr("t3", 2, 2, 20);
    oled_ready = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    oled_ready = 1'b1;
    wait_quiet("t3", 60);
    chk("t3_stall_cycles", stall_cnt, 5);
    chk_line("t3_line", 32'h544F544C);

    // Re-request of line 1 while it is being written.
    clear_logs();
    pulse(4'b0010);
    wait_wr("t4", 1, 1, 20);
    pulse(4'b0010);
    wait_quiet("t4", 100);
    chk_order("t4_order", 2, 16'h1100);
    chk("t4_writes", acc_char.size(), 8);

    // Reset mid-line, then a clean rewrite of line 2.
    clear_logs();
    pulse(4'b0100);
    wait_wr("t5", 2, 2, 20);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_wr_en", oled_wr_en, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("t5_no_done", done_log.size(), 0);
    clear_logs();
    pulse(4'b0100);
    wait_quiet("t5", 60);
    chk_line("t5_line", 32'h544F544C);
    chk_order("t5_order", 1, 16'h2000);

    // Dispense line whose source holds a NUL at column 2.
    clear_logs();
    pulse(4'b1000);
    wait_quiet("t6", 60);
`ifdef OLED_BLANK_PAD_EN
    chk_line("t6_line", 32'h44492020);
`else
    chk_line("t6_line", 32'h44490058);
`endif
    chk_order("t6_order", 1, 16'h3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
